nn_sequencer: RTL and testbench
===============================

// Module: nn_sequencer
// PURPOSE
//  Next-generation top-level sequencer for the neural-network datapath.
//  Handles N layers, mini-batch training with a separate weight-update phase,
//  and one-deep buffering of a pending start request.
//  Captures image/label into registers on acceptance. Drives per-layer fp/bp
//  requests, weight load/update, and display; sits between uart_protocol and the layer engines.
// PARAMETERS
//  IMG_SZ      784<<3  image vector width, bits
//  LABEL_W     8       label width, bits
//  NUM_LAYERS  3       layers sequenced (>=1)
//  BATCH_SIZE  8       training images per weight update (>=1)
//  LW = $clog2(NUM_LAYERS) min 1; BW = $clog2(BATCH_SIZE+1)
// PORTS
//  clk              in   1        clock, rising edge
//  rst_n            in   1        async reset, active low
//  start            in   1        1-cycle pulse: run one image
//  train            in   1        sampled with start: 1=train pass, 0=inference pass
//  image_in         in   IMG_SZ   image, sampled on accepted start
//  label_in         in   LABEL_W  label, sampled on accepted start
//  weights_ack      in   1        weight load complete (pulse)
//  fp_done          in   1        current-layer forward done (pulse)
//  bp_done          in   1        current-layer backprop done (pulse)
//  upd_done         in   1        batch weight update done (pulse)
//  drawn            in   1        display complete (pulse)
//  get_all_weights  out  1        level: request weight load
//  do_fp            out  1        level: forward request for layer_idx
//  do_bp            out  1        level: backprop request for layer_idx
//  do_upd           out  1        level: apply accumulated gradients
//  draw             out  1        level: display result
//  layer_idx        out  LW       layer addressed by do_fp/do_bp
//  ack              out  1        1-cycle pulse: image pass complete
//  busy             out  1        state != IDLE
//  overflow         out  1        1-cycle pulse: start dropped
//  batch_cnt        out  BW       training images accumulated in current batch
//  image_out        out  IMG_SZ   captured image
//  label_out        out  LABEL_W  captured label
// BEHAVIOUR
//  Reset (rst_n low, async): state=LOAD, layer_idx=0, batch_cnt=0, pend=0,
//   image_out/label_out=0, all outputs 0. Requests are Moore-decoded from state,
//   so get_all_weights=1 on the first clk after reset release.
//  States: LOAD, IDLE, FWD, BWD, UPD, DISP.
//  LOAD: get_all_weights=1 until weights_ack; weights_ack -> IDLE next cycle.
//  IDLE: start or pend -> FWD, layer_idx=0; image/label/train from the start
//   inputs if start=1, else from the pend buffer; pend cleared.
//  FWD: do_fp=1. fp_done with layer_idx<NUM_LAYERS-1 -> layer_idx+1, stay in FWD.
//   fp_done on last layer -> BWD (train=1, layer_idx unchanged) or DISP (train=0).
//  BWD: do_bp=1, layers descend. bp_done with layer_idx>0 -> layer_idx-1.
//   bp_done at layer 0 -> batch_cnt+1 and ack.
//   New count==BATCH_SIZE -> UPD; otherwise -> IDLE.
//  UPD: do_upd=1. upd_done -> batch_cnt=0 -> LOAD (reload weights); no ack here.
//  DISP: draw=1. drawn -> ack, -> IDLE; batch_cnt unchanged.
//  ack is registered: it pulses the cycle after the completing done.
//  Start while busy or LOAD: captured into pend (image, label, train) if pend=0.
//   If pend=1, the new start is dropped, overflow pulses, and pend is unchanged.
//  Start arriving with the cycle that leaves for IDLE: it is buffered, then
//   taken from IDLE on the next cycle (1-cycle IDLE min).
//  Done pulses in a non-matching state are ignored (no state change).
//  Requests hold high until their done; at most one of
//   get_all_weights/do_fp/do_bp/do_upd/draw high in any cycle.
//  Reset mid-pass discards pend, the partial batch, and the captured image.
// TESTING
//  1. Reset; weights_ack @5 -> get_all_weights 1 for cycles 1..5, then busy=0.
//  2. NUM_LAYERS=3, start train=0, fp_done x3 -> layer_idx 0,1,2; draw; drawn -> ack 1 cycle.
//  3. train=1 pass -> do_fp layers 0,1,2 then do_bp 2,1,0; ack; batch_cnt 0->1.
//  4. BATCH_SIZE=2, two train passes -> 2nd ack, do_upd; upd_done -> LOAD, batch_cnt=0.
//  5. start during FWD, then start again -> first buffered, overflow pulses once;
//     buffered pass runs with its own image after ack.
//  6. rst_n low mid-BWD with pend=1 -> all outputs 0 immediately; release -> LOAD, no pass.

Source files
------------

// File: rtl/nn_sequencer.sv
// Top-level sequencer for the neural-network datapath: weight load, per-layer
// forward/backprop, batched weight update and display, with a one-deep start buffer.
module nn_sequencer #(
  parameter int unsigned IMG_SZ     = 784 << 3,
  parameter int unsigned LABEL_W    = 8,
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned BATCH_SIZE = 8,
  localparam int unsigned LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int unsigned BW = $clog2(BATCH_SIZE + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               train,
  input  logic [IMG_SZ-1:0]  image_in,
  input  logic [LABEL_W-1:0] label_in,
  input  logic               weights_ack,
  input  logic               fp_done,
  input  logic               bp_done,
  input  logic               upd_done,
  input  logic               drawn,
  output logic               get_all_weights,
  output logic               do_fp,
  output logic               do_bp,
  output logic               do_upd,
  output logic               draw,
  output logic [LW-1:0]      layer_idx,
  output logic               ack,
  output logic               busy,
  output logic               overflow,
  output logic [BW-1:0]      batch_cnt,
  output logic [IMG_SZ-1:0]  image_out,
  output logic [LABEL_W-1:0] label_out
);

  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [BW-1:0] BATCH_FULL = BW'(BATCH_SIZE);

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_FWD,
    S_BWD,
    S_UPD,
    S_DISP
  } state_t;

  state_t             state_q, state_d;
  logic [LW-1:0]      layer_d;
  logic [BW-1:0]      batch_d, batch_inc;
  logic               train_q, train_d;
  logic               pend_q, pend_d;
  logic               pend_train_q, pend_train_d;
  logic [IMG_SZ-1:0]  pend_img_q, pend_img_d, img_d;
  logic [LABEL_W-1:0] pend_lbl_q, pend_lbl_d, lbl_d;
  logic               ack_d, ovf_d;

  // Next-state, datapath capture and pend buffer management
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_idx;
    batch_d      = batch_cnt;
    batch_inc    = batch_cnt + BW'(1);
    train_d      = train_q;
    pend_d       = pend_q;
    pend_train_d = pend_train_q;
    pend_img_d   = pend_img_q;
    pend_lbl_d   = pend_lbl_q;
    img_d        = image_out;
    lbl_d        = label_out;
    ack_d        = 1'b0;
    ovf_d        = 1'b0;

    // Starts outside IDLE go to the single-entry buffer or are dropped
    if (start && (state_q != S_IDLE)) begin
      if (!pend_q) begin
        pend_d       = 1'b1;
        pend_train_d = train;
        pend_img_d   = image_in;
        pend_lbl_d   = label_in;
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      S_LOAD: begin
        if (weights_ack) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (start) begin
          state_d = S_FWD;
          layer_d = '0;
          train_d = train;
          img_d   = image_in;
          lbl_d   = label_in;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          state_d = S_FWD;
          layer_d = '0;
          train_d = pend_train_q;
          img_d   = pend_img_q;
          lbl_d   = pend_lbl_q;
          pend_d  = 1'b0;
        end
      end
      S_FWD: begin
        if (fp_done) begin
          if (layer_idx == LAST_LAYER) begin
            state_d = train_q ? S_BWD : S_DISP;
          end else begin
            layer_d = layer_idx + LW'(1);
          end
        end
      end
      S_BWD: begin
        if (bp_done) begin
          if (layer_idx != '0) begin
            layer_d = layer_idx - LW'(1);
          end else begin
            batch_d = batch_inc;
            ack_d   = 1'b1;
            state_d = (batch_inc == BATCH_FULL) ? S_UPD : S_IDLE;
          end
        end
      end
      S_UPD: begin
        if (upd_done) begin
          batch_d = '0;
          state_d = S_LOAD;
        end
      end
      S_DISP: begin
        if (drawn) begin
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Requests are registered decodes of the next state so they track state exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_LOAD;
      layer_idx       <= '0;
      batch_cnt       <= '0;
      train_q         <= 1'b0;
      pend_q          <= 1'b0;
      pend_train_q    <= 1'b0;
      pend_img_q      <= '0;
      pend_lbl_q      <= '0;
      image_out       <= '0;
      label_out       <= '0;
      get_all_weights <= 1'b0;
      do_fp           <= 1'b0;
      do_bp           <= 1'b0;
      do_upd          <= 1'b0;
      draw            <= 1'b0;
      busy            <= 1'b0;
      ack             <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      state_q         <= state_d;
      layer_idx       <= layer_d;
      batch_cnt       <= batch_d;
      train_q         <= train_d;
      pend_q          <= pend_d;
      pend_train_q    <= pend_train_d;
      pend_img_q      <= pend_img_d;
      pend_lbl_q      <= pend_lbl_d;
      image_out       <= img_d;
      label_out       <= lbl_d;
      get_all_weights <= (state_d == S_LOAD);
      do_fp           <= (state_d == S_FWD);
      do_bp           <= (state_d == S_BWD);
      do_upd          <= (state_d == S_UPD);
      draw            <= (state_d == S_DISP);
      busy            <= (state_d != S_IDLE);
      ack             <= ack_d;
      overflow        <= ovf_d;
    end
  end

endmodule

// File: tb/tb_nn_sequencer.sv
// Randomized bench for nn_sequencer: the bench answers requests as the layer
// engines would and tracks each pass as a script of expected operations.
module tb_nn_sequencer;

  localparam int unsigned IMG_SZ     = 64;
  localparam int unsigned LABEL_W    = 8;
  localparam int unsigned NUM_LAYERS = 3;
  localparam int unsigned BATCH_SIZE = 2;
  localparam int unsigned LW         = 2;
  localparam int unsigned BW         = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start, train;
  logic [IMG_SZ-1:0]  image_in;
  logic [LABEL_W-1:0] label_in;
  logic               weights_ack, fp_done, bp_done, upd_done, drawn;
  logic               get_all_weights, do_fp, do_bp, do_upd, draw;
  logic [LW-1:0]      layer_idx;
  logic               ack, busy, overflow;
  logic [BW-1:0]      batch_cnt;
  logic [IMG_SZ-1:0]  image_out;
  logic [LABEL_W-1:0] label_out;

  nn_sequencer #(
    .IMG_SZ(IMG_SZ), .LABEL_W(LABEL_W), .NUM_LAYERS(NUM_LAYERS), .BATCH_SIZE(BATCH_SIZE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .train(train),
    .image_in(image_in), .label_in(label_in),
    .weights_ack(weights_ack), .fp_done(fp_done), .bp_done(bp_done),
    .upd_done(upd_done), .drawn(drawn),
    .get_all_weights(get_all_weights), .do_fp(do_fp), .do_bp(do_bp),
    .do_upd(do_upd), .draw(draw), .layer_idx(layer_idx), .ack(ack),
    .busy(busy), .overflow(overflow), .batch_cnt(batch_cnt),
    .image_out(image_out), .label_out(label_out)
  );

  always #5 clk = ~clk;

  typedef enum int {K_LOAD, K_FP, K_BP, K_UPD, K_DRAW} kind_t;
  typedef struct {
    kind_t kind;
    int    layer;
  } op_t;

  // Reference model: outstanding operations, batch count, pend buffer, last accepted image
  op_t                script[$];
  int                 batch_m;
  bit                 pend_v, pend_tr_m;
  logic [IMG_SZ-1:0]  pend_img_m, cur_img;
  logic [LABEL_W-1:0] pend_lbl_m, cur_lbl;
  bit                 exp_ack, exp_ovf;
  bit                 did_mid_reset;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_job(input bit tr);
    for (int l = 0; l < int'(NUM_LAYERS); l++) script.push_back(op_t'{K_FP, l});
    if (tr) begin
      for (int l = int'(NUM_LAYERS) - 1; l >= 0; l--) script.push_back(op_t'{K_BP, l});
      if (batch_m + 1 == int'(BATCH_SIZE)) begin
        script.push_back(op_t'{K_UPD, 0});
        script.push_back(op_t'{K_LOAD, 0});
      end
    end else begin
      script.push_back(op_t'{K_DRAW, 0});
    end
  endtask

  task automatic model_reset();
    script.delete();
    script.push_back(op_t'{K_LOAD, 0});
    batch_m = 0;
    pend_v  = 1'b0;
    cur_img = '0;
    cur_lbl = '0;
    exp_ack = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic clear_inputs();
    start = 1'b0; train = 1'b0; image_in = '0; label_in = '0;
    weights_ack = 1'b0; fp_done = 1'b0; bp_done = 1'b0; upd_done = 1'b0; drawn = 1'b0;
  endtask

  task automatic check_zero(input string when);
    check({when, "_get_all_weights"}, 64'(get_all_weights), 64'(0));
    check({when, "_do_fp"}, 64'(do_fp), 64'(0));
    check({when, "_do_bp"}, 64'(do_bp), 64'(0));
    check({when, "_do_upd"}, 64'(do_upd), 64'(0));
    check({when, "_draw"}, 64'(draw), 64'(0));
    check({when, "_layer_idx"}, 64'(layer_idx), 64'(0));
    check({when, "_ack"}, 64'(ack), 64'(0));
    check({when, "_busy"}, 64'(busy), 64'(0));
    check({when, "_overflow"}, 64'(overflow), 64'(0));
    check({when, "_batch_cnt"}, 64'(batch_cnt), 64'(0));
    check({when, "_image_out"}, 64'(image_out), 64'(0));
    check({when, "_label_out"}, 64'(label_out), 64'(0));
  endtask

  // Async reset a little after an edge; ends one clock after release with quiet inputs
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async");
    clear_inputs();
    repeat (3) @(negedge clk);
    check_zero("rst_held");
    model_reset();
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic check_outputs();
    bit    act;
    kind_t hk;
    act = (script.size() != 0);
    hk  = act ? script[0].kind : K_LOAD;
    check("get_all_weights", 64'(get_all_weights), 64'(act && hk == K_LOAD));
    check("do_fp", 64'(do_fp), 64'(act && hk == K_FP));
    check("do_bp", 64'(do_bp), 64'(act && hk == K_BP));
    check("do_upd", 64'(do_upd), 64'(act && hk == K_UPD));
    check("draw", 64'(draw), 64'(act && hk == K_DRAW));
    if (act && (hk == K_FP || hk == K_BP))
      check("layer_idx", 64'(layer_idx), 64'(script[0].layer));
    check("busy", 64'(busy), 64'(act));
    check("ack", 64'(ack), 64'(exp_ack));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("batch_cnt", 64'(batch_cnt), 64'(batch_m));
    check("image_out", 64'(image_out), 64'(cur_img));
    check("label_out", 64'(label_out), 64'(cur_lbl));
  endtask

  // Answer the outstanding request sometimes; occasionally pulse unrelated dones
  task automatic drive_inputs();
    bit    act, fire;
    kind_t hk;
    act      = (script.size() != 0);
    hk       = act ? script[0].kind : K_LOAD;
    fire     = ($urandom_range(99) < 40);
    start    = ($urandom_range(99) < 15);
    train    = 1'($urandom_range(1));
    image_in = {$urandom, $urandom};
    label_in = 8'($urandom);
    weights_ack = (act && hk == K_LOAD) ? fire : ($urandom_range(99) < 5);
    fp_done     = (act && hk == K_FP)   ? fire : ($urandom_range(99) < 5);
    bp_done     = (act && hk == K_BP)   ? fire : ($urandom_range(99) < 5);
    upd_done    = (act && hk == K_UPD)  ? fire : ($urandom_range(99) < 5);
    drawn       = (act && hk == K_DRAW) ? fire : ($urandom_range(99) < 5);
  endtask

  task automatic model_update();
    bit    busy_b, done;
    kind_t hk;
    busy_b  = (script.size() != 0);
    exp_ack = 1'b0;
    exp_ovf = 1'b0;
    if (start && busy_b) begin
      if (!pend_v) begin
        pend_v     = 1'b1;
        pend_tr_m  = train;
        pend_img_m = image_in;
        pend_lbl_m = label_in;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (busy_b) begin
      hk = script[0].kind;
      case (hk)
        K_LOAD:  done = weights_ack;
        K_FP:    done = fp_done;
        K_BP:    done = bp_done;
        K_UPD:   done = upd_done;
        default: done = drawn;
      endcase
      if (done) begin
        if (hk == K_BP && script[0].layer == 0) begin
          exp_ack = 1'b1;
          batch_m++;
        end
        if (hk == K_DRAW) exp_ack = 1'b1;
        if (hk == K_UPD) batch_m = 0;
        void'(script.pop_front());
      end
    end else if (start) begin
      cur_img = image_in;
      cur_lbl = label_in;
      pend_v  = 1'b0;
      build_job(train);
    end else if (pend_v) begin
      cur_img = pend_img_m;
      cur_lbl = pend_lbl_m;
      pend_v  = 1'b0;
      build_job(pend_tr_m);
    end
  endtask

  initial begin
    clear_inputs();
    did_mid_reset = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_outputs();
      drive_inputs();
      @(posedge clk);
      model_update();
      if (!did_mid_reset && cyc > 1000 && script.size() != 0 &&
          script[0].kind == K_BP && pend_v) begin
        did_mid_reset = 1'b1;
        do_reset();
      end
    end
    if (!did_mid_reset) do_reset();
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      check_outputs();
      drive_inputs();
      @(posedge clk);
      model_update();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
